// File: rtl/crypto1_key_check_if.sv
// Candidate subkey handshake between the subkey generators and the key checker.
// Valid/ready: a candidate transfers on a cycle where cand_vld and cand_rdy are both high.
// The master holds cand_even/cand_odd/cand_last stable while cand_vld is high and cand_rdy is low.
interface crypto1_key_check_if;
    logic        cand_vld;
    logic        cand_rdy;
    logic [23:0] cand_even;
    logic [23:0] cand_odd;
    logic        cand_last;

    modport master (
        output cand_vld,
        output cand_even,
        output cand_odd,
        output cand_last,
        input  cand_rdy
    );

    modport slave (
        input  cand_vld,
        input  cand_even,
        input  cand_odd,
        input  cand_last,
        output cand_rdy
    );
endinterface

// File: rtl/crypto1_key_check.sv
// Runs Crypto1 forward from each candidate state and checks it against the captured keystream.
// Latency: a full match shows up CHECK_BITS+1 cycles after accept; a mismatch at step k re-opens at accept+k+2.
// Backpressure: cand_rdy is high only while idle; it stays low while a candidate is checked and after the search ends.
module crypto1_key_check #(
    parameter int CHECK_BITS  = 48,
    parameter int EARLY_ABORT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [47:0]          bitstream,
    crypto1_key_check_if.slave   cand,
    output logic [47:0]          key,
    output logic                 found,
    output logic                 done,
    output logic [31:0]          tested
);

    localparam logic [15:0] FA_TT     = 16'h2C79;
    localparam logic [15:0] FB_TT     = 16'h6671;
    localparam logic [31:0] FC_TT     = 32'h7907287B;
    localparam logic [5:0]  STEP_LAST = 6'(CHECK_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] lfsr_q, lfsr_d;
    logic [47:0] init_q, init_d;
    logic [5:0]  step_q, step_d;
    logic        last_q, last_d;
    logic        miss_q, miss_d;
    logic        rdy_q, rdy_d;
    logic [47:0] key_d;
    logic        found_d;
    logic        done_d;
    logic [31:0] tested_d;

    logic [47:0] load_state;
    logic        ks;
    logic        fb_bit;
    logic        bit_miss;
    logic [31:0] tested_inc;

    function automatic logic fa(input logic a, input logic b, input logic c, input logic d);
        return FA_TT[{a, b, c, d}];
    endfunction

    function automatic logic fb(input logic a, input logic b, input logic c, input logic d);
        return FB_TT[{a, b, c, d}];
    endfunction

    // Even subkey bits land on even state positions, odd subkey bits on odd positions.
    always_comb begin
        load_state = '0;
        for (int i = 0; i < 24; i++) begin
            load_state[2*i]   = cand.cand_even[i];
            load_state[2*i+1] = cand.cand_odd[i];
        end
    end

    always_comb begin
        ks = FC_TT[{fa(lfsr_q[9],  lfsr_q[11], lfsr_q[13], lfsr_q[15]),
                    fb(lfsr_q[17], lfsr_q[19], lfsr_q[21], lfsr_q[23]),
                    fa(lfsr_q[25], lfsr_q[27], lfsr_q[29], lfsr_q[31]),
                    fa(lfsr_q[33], lfsr_q[35], lfsr_q[37], lfsr_q[39]),
                    fb(lfsr_q[41], lfsr_q[43], lfsr_q[45], lfsr_q[47])}];
        fb_bit = lfsr_q[0]  ^ lfsr_q[5]  ^ lfsr_q[9]  ^ lfsr_q[10] ^ lfsr_q[12] ^ lfsr_q[14] ^
                 lfsr_q[15] ^ lfsr_q[17] ^ lfsr_q[19] ^ lfsr_q[24] ^ lfsr_q[25] ^ lfsr_q[27] ^
                 lfsr_q[29] ^ lfsr_q[35] ^ lfsr_q[39] ^ lfsr_q[41] ^ lfsr_q[42] ^ lfsr_q[43];
    end

    assign bit_miss   = (ks != bitstream[step_q]);
    assign tested_inc = (tested == 32'hFFFF_FFFF) ? tested : tested + 32'd1;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        init_d   = init_q;
        step_d   = step_q;
        last_d   = last_q;
        miss_d   = miss_q;
        rdy_d    = 1'b0;
        key_d    = key;
        found_d  = found;
        done_d   = done;
        tested_d = tested;

        unique case (state_q)
            IDLE: begin
                if (cand.cand_vld && rdy_q) begin
                    lfsr_d  = load_state;
                    init_d  = load_state;
                    step_d  = '0;
                    last_d  = cand.cand_last;
                    miss_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            RUN: begin
                lfsr_d = {fb_bit, lfsr_q[47:1]};
                step_d = step_q + 6'd1;
                if ((EARLY_ABORT != 0) && bit_miss) begin
                    tested_d = tested_inc;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (step_q == STEP_LAST) begin
                    tested_d = tested_inc;
                    if (!(miss_q || bit_miss)) begin
                        key_d   = init_q;
                        found_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = HALT;
                    end else if (last_q) begin
                        done_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    // Without early abort the miss is remembered until the last step.
                    miss_d = miss_q | bit_miss;
                end
            end
            HALT: begin
                rdy_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            init_q  <= '0;
            step_q  <= '0;
            last_q  <= 1'b0;
            miss_q  <= 1'b0;
            rdy_q   <= 1'b0;
            key     <= '0;
            found   <= 1'b0;
            done    <= 1'b0;
            tested  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            init_q  <= init_d;
            step_q  <= step_d;
            last_q  <= last_d;
            miss_q  <= miss_d;
            rdy_q   <= rdy_d;
            key     <= key_d;
            found   <= found_d;
            done    <= done_d;
            tested  <= tested_d;
        end
    end

    assign cand.cand_rdy = rdy_q;

endmodule

// File: tb/tb_crypto1_key_check.sv
// Directed checks of crypto1_key_check at full, reduced and single-bit check widths, with and without early abort.
module tb_crypto1_key_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] bitstream;
    logic        vld;
    logic [1:0]  sel;
    logic [23:0] even;
    logic [23:0] odd;
    logic        last;

    logic [47:0] key    [4];
    logic        found  [4];
    logic        done   [4];
    logic [31:0] tested [4];
    logic        rdy    [4];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    crypto1_key_check_if ifc0();
    crypto1_key_check_if ifc1();
    crypto1_key_check_if ifc2();
    crypto1_key_check_if ifc3();

    assign ifc0.cand_vld = vld && (sel == 2'd0);
    assign ifc1.cand_vld = vld && (sel == 2'd1);
    assign ifc2.cand_vld = vld && (sel == 2'd2);
    assign ifc3.cand_vld = vld && (sel == 2'd3);
    assign ifc0.cand_even = even;  assign ifc0.cand_odd = odd;  assign ifc0.cand_last = last;
    assign ifc1.cand_even = even;  assign ifc1.cand_odd = odd;  assign ifc1.cand_last = last;
    assign ifc2.cand_even = even;  assign ifc2.cand_odd = odd;  assign ifc2.cand_last = last;
    assign ifc3.cand_even = even;  assign ifc3.cand_odd = odd;  assign ifc3.cand_last = last;
    assign rdy[0] = ifc0.cand_rdy;
    assign rdy[1] = ifc1.cand_rdy;
    assign rdy[2] = ifc2.cand_rdy;
    assign rdy[3] = ifc3.cand_rdy;

    crypto1_key_check #(.CHECK_BITS(48), .EARLY_ABORT(1)) u_full (
        .clk(clk), .rst_n(rst_n), .bitstream(bitstream), .cand(ifc0.slave),
        .key(key[0]), .found(found[0]), .done(done[0]), .tested(tested[0]));
    crypto1_key_check #(.CHECK_BITS(8), .EARLY_ABORT(1)) u_cb8 (
        .clk(clk), .rst_n(rst_n), .bitstream(bitstream), .cand(ifc1.slave),
        .key(key[1]), .found(found[1]), .done(done[1]), .tested(tested[1]));
    crypto1_key_check #(.CHECK_BITS(1), .EARLY_ABORT(1)) u_cb1 (
        .clk(clk), .rst_n(rst_n), .bitstream(bitstream), .cand(ifc2.slave),
        .key(key[2]), .found(found[2]), .done(done[2]), .tested(tested[2]));
    crypto1_key_check #(.CHECK_BITS(8), .EARLY_ABORT(0)) u_noab (
        .clk(clk), .rst_n(rst_n), .bitstream(bitstream), .cand(ifc3.slave),
        .key(key[3]), .found(found[3]), .done(done[3]), .tested(tested[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
    endtask

    // Present one candidate to DUT idx while it is ready; returns 1 unit after the accepting edge.
    task automatic accept(input logic [1:0] idx, input logic [23:0] e, input logic [23:0] o, input logic l);
        chk("accept_rdy", 64'(rdy[idx]), 64'd1);
        sel  = idx;
        even = e;
        odd  = o;
        last = l;
        vld  = 1'b1;
        wait_cyc(1);
        vld  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        vld       = 1'b0;
        sel       = 2'd0;
        even      = '0;
        odd       = '0;
        last      = 1'b0;
        bitstream = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_key",    64'(key[0]),    64'd0);
        chk("rst_found",  64'(found[0]),  64'd0);
        chk("rst_done",   64'(done[0]),   64'd0);
        chk("rst_tested", 64'(tested[0]), 64'd0);
        chk("rst_rdy",    64'(rdy[0]),    64'd0);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("post_rst_rdy", 64'(rdy[0]), 64'd1);

        // Zero candidate against all-zero keystream: full 48-bit match
        bitstream = 48'h0;
        accept(2'd0, 24'h0, 24'h0, 1'b0);
        chk("zero_rdy_busy", 64'(rdy[0]), 64'd0);
        wait_cyc(47);
        chk("zero_found_early", 64'(found[0]), 64'd0);
        wait_cyc(1);
        chk("zero_found",  64'(found[0]),  64'd1);
        chk("zero_done",   64'(done[0]),   64'd1);
        chk("zero_key",    64'(key[0]),    64'h0);
        chk("zero_tested", 64'(tested[0]), 64'd1);
        chk("zero_rdy",    64'(rdy[0]),    64'd0);
        wait_cyc(3);
        chk("halt_found_held", 64'(found[0]), 64'd1);
        chk("halt_rdy",        64'(rdy[0]),   64'd0);

        // Immediate mismatch then exhaustion on a last candidate
        do_reset();
        bitstream = 48'h1;
        accept(2'd0, 24'h0, 24'h0, 1'b0);
        chk("mis_rdy_busy", 64'(rdy[0]), 64'd0);
        wait_cyc(1);
        chk("mis_rdy",    64'(rdy[0]),    64'd1);
        chk("mis_found",  64'(found[0]),  64'd0);
        chk("mis_done",   64'(done[0]),   64'd0);
        chk("mis_tested", 64'(tested[0]), 64'd1);
        accept(2'd0, 24'h0, 24'h0, 1'b1);
        wait_cyc(1);
        chk("exh_done",   64'(done[0]),   64'd1);
        chk("exh_found",  64'(found[0]),  64'd0);
        chk("exh_tested", 64'(tested[0]), 64'd2);
        wait_cyc(2);
        chk("exh_rdy", 64'(rdy[0]), 64'd0);

        // Backpressure: valid held high across two mismatching candidates
        do_reset();
        bitstream = 48'h1;
        sel = 2'd0; even = '0; odd = '0; last = 1'b0;
        vld = 1'b1;
        wait_cyc(1);
        chk("bp_rdy0",    64'(rdy[0]),    64'd0);
        wait_cyc(1);
        chk("bp_rdy1",    64'(rdy[0]),    64'd1);
        chk("bp_tested1", 64'(tested[0]), 64'd1);
        wait_cyc(1);
        chk("bp_rdy2",    64'(rdy[0]),    64'd0);
        chk("bp_tested2", 64'(tested[0]), 64'd1);
        wait_cyc(1);
        vld = 1'b0;
        chk("bp_tested3", 64'(tested[0]), 64'd2);

        // Eight-bit check width; upper keystream bits must be ignored
        do_reset();
        bitstream = 48'hFFFF_FFFF_FF00;
        accept(2'd1, 24'h0, 24'h0, 1'b0);
        wait_cyc(7);
        chk("cb8_found_early", 64'(found[1]), 64'd0);
        wait_cyc(1);
        chk("cb8_found",  64'(found[1]),  64'd1);
        chk("cb8_done",   64'(done[1]),   64'd1);
        chk("cb8_tested", 64'(tested[1]), 64'd1);

        // Single-bit check width: odd[23] drives s47 so the first keystream bit is 1
        do_reset();
        bitstream = 48'h1;
        accept(2'd2, 24'h0, 24'h80_0000, 1'b0);
        chk("cb1_found_early", 64'(found[2]), 64'd0);
        wait_cyc(1);
        chk("cb1_found", 64'(found[2]), 64'd1);
        chk("cb1_key",   64'(key[2]),   64'h8000_0000_0000);

        do_reset();
        bitstream = 48'h0;
        accept(2'd2, 24'h0, 24'h80_0000, 1'b0);
        wait_cyc(1);
        chk("cb1_mis_found",  64'(found[2]),  64'd0);
        chk("cb1_mis_rdy",    64'(rdy[2]),    64'd1);
        chk("cb1_mis_tested", 64'(tested[2]), 64'd1);
        accept(2'd2, 24'hFF_FFFF, 24'h0, 1'b1);
        wait_cyc(1);
        chk("cb1_even_found",  64'(found[2]),  64'd1);
        chk("cb1_even_done",   64'(done[2]),   64'd1);
        chk("cb1_even_key",    64'(key[2]),    64'h5555_5555_5555);
        chk("cb1_even_tested", 64'(tested[2]), 64'd2);

        // No early abort: a step-0 miss still runs all eight steps
        do_reset();
        bitstream = 48'h1;
        accept(2'd3, 24'h0, 24'h0, 1'b0);
        wait_cyc(1);
        chk("noab_rdy_step1", 64'(rdy[3]), 64'd0);
        wait_cyc(6);
        chk("noab_rdy_step7", 64'(rdy[3]), 64'd0);
        wait_cyc(1);
        chk("noab_rdy",    64'(rdy[3]),    64'd1);
        chk("noab_found",  64'(found[3]),  64'd0);
        chk("noab_tested", 64'(tested[3]), 64'd1);

        // Reset in the middle of a run clears everything, including earlier counts
        do_reset();
        bitstream = 48'h1;
        accept(2'd0, 24'h0, 24'h0, 1'b0);
        wait_cyc(1);
        chk("pre_rst_tested", 64'(tested[0]), 64'd1);
        bitstream = 48'h0;
        accept(2'd0, 24'h0, 24'h0, 1'b0);
        wait_cyc(20);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy",    64'(rdy[0]),    64'd0);
        chk("midrst_found",  64'(found[0]),  64'd0);
        chk("midrst_done",   64'(done[0]),   64'd0);
        chk("midrst_key",    64'(key[0]),    64'd0);
        chk("midrst_tested", 64'(tested[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("midrst_rdy_after",    64'(rdy[0]),    64'd1);
        chk("midrst_tested_after", 64'(tested[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto1_key_check.md
Name: crypto1_key_check

Overview:
- Downstream stage of the per-core subkey generators.
- Accepts candidate (even, odd) 24-bit subkey pairs and interleaves each pair into a 48-bit Crypto1 LFSR state.
- Clocks the cipher forward and compares the produced keystream against the captured BITSTREAM.
- Reports the first fully matching state as KEY with sticky FOUND, or reports exhaustion via DONE.

Parameters:
- CHECK_BITS, 48: number of keystream bits compared, legal range 1..48.
- EARLY_ABORT, 1: 1 = drop a candidate on its first mismatching bit; 0 = always run CHECK_BITS steps.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- BITSTREAM  in  48  observed keystream; bit 0 is the first bit. Held stable while not DONE.
- CAND_VALID  in  1  candidate pair present.
- CAND_READY  out  1  block accepts a candidate this cycle.
- CAND_EVEN  in  24  even subkey.
- CAND_ODD  in  24  odd subkey.
- CAND_LAST  in  1  qualifies the final candidate of the subspace.
- KEY  out  48  matching initial LFSR state; valid while FOUND=1.
- FOUND  out  1  sticky; a full match was found.
- DONE  out  1  sticky; search finished (match found or last candidate rejected).
- TESTED  out  32  count of candidates fully retired, saturating at 2^32-1.

Behaviour:
- Reset (async assert, sync deassert by design upstream):
  - KEY=0, FOUND=0, DONE=0, TESTED=0, CAND_READY=0, FSM=IDLE.
  - Reset mid-RUN discards the candidate in flight and does not increment TESTED.
- Load mapping: s[2i]=CAND_EVEN[i], s[2i+1]=CAND_ODD[i], for i=0..23.
- Filter:
  - ks = fc(fa(s9,s11,s13,s15), fb(s17,s19,s21,s23), fa(s25,s27,s29,s31), fa(s33,s35,s37,s39), fb(s41,s43,s45,s47)).
  - Truth tables are indexed with the first-listed input as MSB: fa=16'h2C79, fb=16'h6671, fc=32'h7907287B.
- Step:
  - fb_bit = XOR of s at {0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43}.
  - s_next = {fb_bit, s[47:1]}.
  - ks is computed from s before the shift.
- FSM states IDLE, RUN, HALT:
  - IDLE: CAND_READY=1. On CAND_VALID&CAND_READY, load s, save the initial state, step=0, latch CAND_LAST, go RUN.
  - RUN:
    - CAND_READY=0. Each cycle compare ks with BITSTREAM[step], then shift and increment step.
    - Mismatch with EARLY_ABORT=1: TESTED++; go HALT with DONE=1 if the latched last flag is set, else go IDLE.
    - EARLY_ABORT=0: record the mismatch and retire at step CHECK_BITS-1.
    - step==CHECK_BITS-1 with no mismatch: KEY=saved initial state, FOUND=1, DONE=1, TESTED++, go HALT.
    - Last candidate retired without a match: DONE=1, FOUND=0, go HALT.
  - HALT: CAND_READY=0; all outputs held until reset.
- Latency (accept in cycle t):
  - Full match: FOUND and KEY visible at cycle t+CHECK_BITS+1.
  - Mismatch at step k: CAND_READY high again at cycle t+k+2.
- Boundaries:
  - CAND_LAST on a matching candidate yields FOUND=1 and DONE=1 together.
  - CAND_VALID without CAND_READY: inputs are ignored; the upstream block must hold them.
  - BITSTREAM bits at index CHECK_BITS and above are ignored.

Test Plan:
- Zero candidate, full match: CAND_EVEN=0, CAND_ODD=0, BITSTREAM=0 -> FOUND=1, DONE=1, KEY=48'h0 at accept+49 cycles, TESTED=1.
- Immediate mismatch: zero candidate (not last), BITSTREAM=48'h1 -> no FOUND, CAND_READY high at accept+2, TESTED=1.
- Exhaustion: zero candidate with CAND_LAST=1, BITSTREAM=48'h1 -> DONE=1, FOUND=0, CAND_READY stays 0.
- Backpressure: two back-to-back zero candidates, BITSTREAM=48'h1, CAND_VALID held high -> second accepted only when CAND_READY returns; TESTED=2.
- Reduced check width: CHECK_BITS=8, zero candidate, BITSTREAM=48'hFFFF_FFFF_FF00 -> FOUND=1 at accept+9.
- Reset: assert RESETn=0 during RUN step 20 -> all outputs 0 immediately; after release, CAND_READY=1 and TESTED=0.
